// File: rtl/codec_pkg.sv
// Shared codec constants: 8x8 block geometry and the JPEG zigzag-to-raster map.
package codec_pkg;

  localparam int BLK_DIM  = 32'd8;
  localparam int BLK_SIZE = 32'd64;
  localparam int IDX_W    = 32'd6;

  // Entry k holds the raster index u*8+v (u = row) of zigzag position k.
  localparam logic [IDX_W-1:0] ZZ_LUT [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [IDX_W-1:0] zz_to_raster(input logic [IDX_W-1:0] k);
    return ZZ_LUT[k];
  endfunction

endpackage

// File: rtl/ffen.sv
// Enable flop with asynchronous active-low clear, used for all control state.
module ffen #(
  parameter int W = 32'd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; clear to zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/zz_bank.sv
// 64-entry coefficient bank: one synchronous write port, one combinational read port.
module zz_bank
  import codec_pkg::*;
#(
  parameter int DATA_W = 32'd12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [BLK_SIZE];

  // Contents are deliberately not reset; unwritten entries keep stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 block buffer: raster-addressed writes in, zigzag-ordered stream out.
module zigzag_buffer
  import codec_pkg::*;
#(
  parameter int DATA_W = 32'd12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_u,
  input  logic [2:0]        in_v,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              out_last,
  input  logic              out_ready
);

  logic [1:0]        full_r;
  logic [1:0]        full_nxt_s;
  logic [1:0]        set_s;
  logic [1:0]        clr_s;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [IDX_W-1:0]  k_r;
  logic              wr_fire_s;
  logic              blk_done_s;
  logic              rd_fire_s;
  logic              rd_wrap_s;
  logic [IDX_W-1:0]  waddr_s;
  logic [IDX_W-1:0]  raddr_s;
  logic [DATA_W-1:0] rdata0_s;
  logic [DATA_W-1:0] rdata1_s;

  assign in_ready   = ~full_r[wr_bank_r];
  assign out_valid  = full_r[rd_bank_r];
  assign wr_fire_s  = in_valid & in_ready;
  assign blk_done_s = wr_fire_s & in_last;
  assign rd_fire_s  = out_valid & out_ready;
  assign rd_wrap_s  = rd_fire_s & (k_r == 6'd63);

  // Fill and drain always target different banks, so set and clear never collide.
  assign set_s      = {1'b0, blk_done_s} << wr_bank_r;
  assign clr_s      = {1'b0, rd_wrap_s} << rd_bank_r;
  assign full_nxt_s = (full_r | set_s) & ~clr_s;

  ffen #(.W(32'd2)) u_full (
    .clk(clk), .rst_n(rst), .en(blk_done_s | rd_wrap_s), .d(full_nxt_s), .q(full_r)
  );

  ffen #(.W(32'd1)) u_wr_bank (
    .clk(clk), .rst_n(rst), .en(blk_done_s), .d(~wr_bank_r), .q(wr_bank_r)
  );

  ffen #(.W(32'd1)) u_rd_bank (
    .clk(clk), .rst_n(rst), .en(rd_wrap_s), .d(~rd_bank_r), .q(rd_bank_r)
  );

  ffen #(.W(IDX_W)) u_k (
    .clk(clk), .rst_n(rst), .en(rd_fire_s), .d(k_r + 6'd1), .q(k_r)
  );

  assign waddr_s = {in_u, in_v};
  assign raddr_s = zz_to_raster(k_r);

  zz_bank #(.DATA_W(DATA_W)) u_bank0 (
    .clk(clk), .we(wr_fire_s & ~wr_bank_r), .waddr(waddr_s), .wdata(in_data),
    .raddr(raddr_s), .rdata(rdata0_s)
  );

  zz_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk(clk), .we(wr_fire_s & wr_bank_r), .waddr(waddr_s), .wdata(in_data),
    .raddr(raddr_s), .rdata(rdata1_s)
  );

  // Present the draining bank's coefficient, forced to zero when nothing is valid.
  always_comb begin
    out_data = '0;
    if (!out_valid) begin
      out_data = '0;
    end else if (rd_bank_r) begin
      out_data = rdata1_s;
    end else begin
      out_data = rdata0_s;
    end
  end

  assign out_idx  = k_r;
  assign out_last = out_valid & (k_r == 6'd63);

endmodule

// File: tb/tb_zigzag_buffer.sv
// Directed self-checking bench for zigzag_buffer.
module tb_zigzag_buffer;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [2:0]    in_u;
  logic [2:0]    in_v;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [5:0]    out_idx;
  logic          out_last;
  logic          out_ready;

  int total = 0;
  int bad = 0;
  int zz [64];
  logic [DW-1:0] blk [4][64];

  zigzag_buffer #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_u(in_u), .in_v(in_v),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Walk the anti-diagonals to build the zigzag order independently of the RTL table.
  task automatic build_zz();
    int u = 0;
    int v = 0;
    for (int k = 0; k < 64; k++) begin
      zz[k] = u * 8 + v;
      if (((u + v) % 2) == 0) begin
        if (v == 7) u++;
        else if (u == 0) v++;
        else begin u--; v++; end
      end else begin
        if (u == 7) v++;
        else if (v == 0) u++;
        else begin u++; v--; end
      end
    end
  endtask

  task automatic wr(input int r, input int d, input logic last);
    in_valid = 1'b1;
    in_u     = 3'(r / 8);
    in_v     = 3'(r % 8);
    in_data  = DW'(d);
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_last = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1)); in_u = 3'($urandom); in_v = 3'($urandom);
      in_data = DW'($urandom);
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'd0 ||
          out_last !== 1'b0 || out_idx !== 6'd0) begin
        bad++;
        $display("FAIL reset_hold: rdy=%b vld=%b data=%0d last=%b idx=%0d, want 1 0 0 0 0",
                 in_ready, out_valid, out_data, out_last, out_idx);
      end
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'd0 || out_idx !== 6'd0) begin
        bad++;
        $display("FAIL reset_release: rdy=%b vld=%b data=%0d idx=%0d, want 1 0 0 0",
                 in_ready, out_valid, out_data, out_idx);
      end
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    for (int r = 0; r < 63; r++) wr(r, r, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_early_valid: out_valid=%b want 0", out_valid);
    end
    wr(63, 63, 1'b1);
    for (int k = 0; k < 64; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== 6'(k) || out_data !== DW'(zz[k]) ||
          out_last !== (k == 63)) begin
        bad++;
        $display("FAIL single_k%0d: vld=%b idx=%0d data=%0d last=%b, want 1 %0d %0d %b",
                 k, out_valid, out_idx, out_data, out_last, k, zz[k], (k == 63));
      end
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL single_after: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_pingpong();
    out_ready = 1'b0;
    for (int r = 0; r < 64; r++) wr(r, 100 + r, r == 63);
    for (int r = 0; r < 64; r++) wr(r, 200 + r, r == 63);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL pp_full: in_ready=%b want 0", in_ready);
    end
    for (int r = 0; r < 10; r++) wr(r, 999, 1'b1);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 6'd0 || out_data !== 12'd100) begin
      bad++;
      $display("FAIL pp_ignored: rdy=%b vld=%b idx=%0d data=%0d, want 0 1 0 100",
               in_ready, out_valid, out_idx, out_data);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== 6'(k) || out_data !== DW'(100 + zz[k]) ||
          in_ready !== 1'b0) begin
        bad++;
        $display("FAIL pp_a_k%0d: vld=%b idx=%0d data=%0d rdy=%b, want 1 %0d %0d 0",
                 k, out_valid, out_idx, out_data, in_ready, k, 100 + zz[k]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL pp_ready_return: in_ready=%b want 1", in_ready);
    end
    for (int k = 0; k < 64; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== 6'(k) || out_data !== DW'(200 + zz[k])) begin
        bad++;
        $display("FAIL pp_b_k%0d: vld=%b idx=%0d data=%0d, want 1 %0d %0d",
                 k, out_valid, out_idx, out_data, k, 200 + zz[k]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL pp_after: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 64; r++) blk[b][r] = DW'($urandom);
    fork
      begin : writer
        int b = 0;
        int r = 0;
        int cyc = 0;
        logic acc;
        while (b < 4 && cyc < 4000) begin
          in_valid = 1'b1; in_u = 3'(r / 8); in_v = 3'(r % 8);
          in_data = blk[b][r]; in_last = (r == 63);
          acc = in_ready;
          @(posedge clk); #1;
          cyc++;
          if (acc) begin
            r++;
            if (r == 64) begin r = 0; b++; end
          end
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++;
        if (b != 4) begin
          bad++; $display("FAIL bp_writer_timeout: blocks=%0d want 4", b);
        end
      end
      begin : reader
        int n = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic [5:0] pidx = 6'd0;
        logic [DW-1:0] pdat = '0;
        while (n < 256 && cyc < 4000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (stall) begin
            total++;
            if (out_valid !== 1'b1 || out_idx !== pidx || out_data !== pdat) begin
              bad++;
              $display("FAIL bp_stable: vld=%b idx=%0d data=%0d, want 1 %0d %0d",
                       out_valid, out_idx, out_data, pidx, pdat);
            end
          end
          if (out_valid === 1'b1 && out_ready) begin
            total++;
            if (out_idx !== 6'(n % 64) || out_data !== blk[n / 64][zz[n % 64]]) begin
              bad++;
              $display("FAIL bp_xfer%0d: idx=%0d data=%0d, want %0d %0d",
                       n, out_idx, out_data, n % 64, blk[n / 64][zz[n % 64]]);
            end
            n++;
          end
          stall = (out_valid === 1'b1) && !out_ready;
          pidx = out_idx;
          pdat = out_data;
          @(posedge clk); #1;
          cyc++;
        end
        out_ready = 1'b0;
        total++;
        if (n != 256) begin
          bad++; $display("FAIL bp_reader_timeout: transfers=%0d want 256", n);
        end
      end
    join
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_after: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_corner();
    out_ready = 1'b0;
    wr(28, 5, 1'b0);
    wr(28, 9, 1'b0);
    wr(63, 1, 1'b1);
    for (int r = 0; r < 64; r++) wr(r, 7, r == 63);
    for (int i = 0; i < 4; i++) wr(28, 12'hABC, 1'b1);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_idx !== 6'd0) begin
      bad++;
      $display("FAIL corner_ignored: rdy=%b vld=%b idx=%0d, want 0 1 0", in_ready, out_valid, out_idx);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (zz[k] == 28 || zz[k] == 63) begin
        total++;
        if (out_data !== ((zz[k] == 28) ? 12'd9 : 12'd1)) begin
          bad++;
          $display("FAIL corner_raster%0d: data=%0d want %0d", zz[k], out_data,
                   (zz[k] == 28) ? 9 : 1);
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 64; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 12'd7) begin
        bad++; $display("FAIL corner_b_k%0d: vld=%b data=%0d want 1 7", k, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL corner_after: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 64; r++) wr(r, 300 + r, r == 63);
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; end
    total++;
    if (out_idx !== 6'd20) begin
      bad++; $display("FAIL mr_pre: idx=%0d want 20", out_idx);
    end
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 6'd0 || out_data !== 12'd0) begin
      bad++;
      $display("FAIL mr_async: vld=%b rdy=%b idx=%0d data=%0d, want 0 1 0 0",
               out_valid, in_ready, out_idx, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 64; r++) wr(r, 400 + r, r == 63);
    for (int k = 0; k < 64; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_idx !== 6'(k) || out_data !== DW'(400 + zz[k])) begin
        bad++;
        $display("FAIL mr_k%0d: vld=%b idx=%0d data=%0d, want 1 %0d %0d",
                 k, out_valid, out_idx, out_data, k, 400 + zz[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_u = 3'd0; in_v = 3'd0;
    in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    build_zz();
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_pingpong();
    test_backpressure();
    test_corner();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
